// File: rtl/ibex_multdiv_iter.sv
// Iterative RV32M multiplier/divider that time-shares the ALU adder:
// 32 shift-add or restoring-divide steps, then one cycle of sign fix-up.
module ibex_multdiv_iter (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [2:0]  md_op_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        kill_i,
   output logic        ready_o,
   output logic        valid_o,
   output logic [31:0] result_o,
   output logic        multdiv_sel_o,
   output logic [32:0] multdiv_operand_a_o,
   output logic [32:0] multdiv_operand_b_o,
   input  logic [33:0] alu_adder_ext_i
);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ITER   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] acc_reg, acc_next;      // product high word / partial remainder
   logic [31:0] mpl_reg, mpl_next;      // multiplier (shifts out) / quotient (shifts in)
   logic [31:0] mcand_reg, mcand_next;  // multiplicand / divisor magnitude
   logic [4:0]  cnt_reg, cnt_next;
   logic [2:0]  op_reg, op_next;
   logic        neg_reg, neg_next;
   logic        div_zero_reg, div_zero_next;
   logic [31:0] result_reg, result_next;

   logic        sa, sb;
   logic [31:0] mag_a, mag_b;
   logic [32:0] div_t;
   logic [31:0] adder_sum;
   logic        adder_carry;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix, fin_result;
   logic        unused_ext;

   assign adder_sum   = alu_adder_ext_i[32:1];
   assign adder_carry = alu_adder_ext_i[33];
   assign unused_ext  = alu_adder_ext_i[0];
   assign div_t       = {acc_reg, mpl_reg[31]};

   always_comb begin
      sa = 1'b0;
      sb = 1'b0;
      if (md_op_i == OP_MULH || md_op_i == OP_MULHSU ||
          md_op_i == OP_DIV  || md_op_i == OP_REM) begin
         sa = op_a_i[31];
      end
      if (md_op_i == OP_MULH || md_op_i == OP_DIV || md_op_i == OP_REM) begin
         sb = op_b_i[31];
      end
      mag_a = sa ? (~op_a_i + 32'd1) : op_a_i;
      mag_b = sb ? (~op_b_i + 32'd1) : op_b_i;
   end

   // Divide-by-zero leaves the dividend magnitude in acc, so only the quotient needs forcing.
   always_comb begin
      prod_fix   = neg_reg ? (~{acc_reg, mpl_reg} + 64'd1) : {acc_reg, mpl_reg};
      quot_fix   = div_zero_reg ? 32'hFFFF_FFFF : (neg_reg ? (~mpl_reg + 32'd1) : mpl_reg);
      rem_fix    = neg_reg ? (~acc_reg + 32'd1) : acc_reg;
      fin_result = 32'd0;
      case (op_reg)
         OP_MUL:                        fin_result = prod_fix[31:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  fin_result = prod_fix[63:32];
         OP_DIV, OP_DIVU:               fin_result = quot_fix;
         OP_REM, OP_REMU:               fin_result = rem_fix;
         default:                       fin_result = 32'd0;
      endcase
   end

   always_comb begin
      state_next          = state_reg;
      acc_next            = acc_reg;
      mpl_next            = mpl_reg;
      mcand_next          = mcand_reg;
      cnt_next            = cnt_reg;
      op_next             = op_reg;
      neg_next            = neg_reg;
      div_zero_next       = div_zero_reg;
      result_next         = result_reg;
      ready_o             = 1'b0;
      valid_o             = 1'b0;
      result_o            = result_reg;
      multdiv_sel_o       = 1'b0;
      multdiv_operand_a_o = 33'd0;
      multdiv_operand_b_o = 33'd0;

      case (state_reg)
         IDLE: begin
            ready_o = 1'b1;
            if (start_i) begin
               state_next    = ITER;
               cnt_next      = 5'd31;
               op_next       = md_op_i;
               acc_next      = 32'd0;
               mpl_next      = md_op_i[2] ? mag_a : mag_b;
               mcand_next    = md_op_i[2] ? mag_b : mag_a;
               neg_next      = (md_op_i == OP_REM) ? sa : (sa ^ sb);
               div_zero_next = (op_b_i == 32'd0);
            end
         end
         ITER: begin
            multdiv_sel_o = 1'b1;
            cnt_next      = cnt_reg - 5'd1;
            if (op_reg[2]) begin
               multdiv_operand_a_o = {div_t[31:0], 1'b1};
               multdiv_operand_b_o = {~mcand_reg, 1'b1};
               if (div_t[32] || adder_carry) begin
                  acc_next = adder_sum;
                  mpl_next = {mpl_reg[30:0], 1'b1};
               end else begin
                  acc_next = div_t[31:0];
                  mpl_next = {mpl_reg[30:0], 1'b0};
               end
            end else begin
               multdiv_operand_a_o = {acc_reg, 1'b1};
               multdiv_operand_b_o = {(mpl_reg[0] ? mcand_reg : 32'd0), 1'b0};
               acc_next = {adder_carry, adder_sum[31:1]};
               mpl_next = {adder_sum[0], mpl_reg[31:1]};
            end
            if (cnt_reg == 5'd0) begin
               state_next = FINISH;
            end
            if (kill_i) begin
               state_next = IDLE;
            end
         end
         FINISH: begin
            state_next = IDLE;
            if (!kill_i) begin
               valid_o     = 1'b1;
               result_o    = fin_result;
               result_next = fin_result;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= IDLE;
         acc_reg      <= 32'd0;
         mpl_reg      <= 32'd0;
         mcand_reg    <= 32'd0;
         cnt_reg      <= 5'd0;
         op_reg       <= 3'd0;
         neg_reg      <= 1'b0;
         div_zero_reg <= 1'b0;
         result_reg   <= 32'd0;
      end else begin
         state_reg    <= state_next;
         acc_reg      <= acc_next;
         mpl_reg      <= mpl_next;
         mcand_reg    <= mcand_next;
         cnt_reg      <= cnt_next;
         op_reg       <= op_next;
         neg_reg      <= neg_next;
         div_zero_reg <= div_zero_next;
         result_reg   <= result_next;
      end
   end

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed bench for ibex_multdiv_iter; a behavioural adder stands in for the ALU.
module tb_ibex_multdiv_iter;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [2:0]  md_op_i = 3'd0;
   logic [31:0] op_a_i = 32'd0;
   logic [31:0] op_b_i = 32'd0;
   logic        kill_i = 1'b0;
   logic        ready_o, valid_o, multdiv_sel_o;
   logic [31:0] result_o;
   logic [32:0] multdiv_operand_a_o, multdiv_operand_b_o;
   logic [33:0] alu_adder_ext_i;

   int vectors = 0;
   int fails   = 0;

   always #5 clk_i = ~clk_i;

   assign alu_adder_ext_i = {1'b0, multdiv_operand_a_o} + {1'b0, multdiv_operand_b_o};

   ibex_multdiv_iter dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .start_i             (start_i),
      .md_op_i             (md_op_i),
      .op_a_i              (op_a_i),
      .op_b_i              (op_b_i),
      .kill_i              (kill_i),
      .ready_o             (ready_o),
      .valid_o             (valid_o),
      .result_o            (result_o),
      .multdiv_sel_o       (multdiv_sel_o),
      .multdiv_operand_a_o (multdiv_operand_a_o),
      .multdiv_operand_b_o (multdiv_operand_b_o),
      .alu_adder_ext_i     (alu_adder_ext_i)
   );

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Issues one request and waits for its result; optional per-cycle adder check for divides.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input bit chk_proto, input bit kill_with_start);
      int          cyc;
      bit          seen;
      logic [31:0] r, q;
      logic [32:0] t;
      start_i = 1'b1;
      md_op_i = op;
      op_a_i  = a;
      op_b_i  = b;
      kill_i  = kill_with_start;
      check({tag, " ready@0"}, {32'd0, ready_o}, 33'd1);
      if (chk_proto) check({tag, " sel@0"}, {32'd0, multdiv_sel_o}, 33'd0);
      r = 32'd0;
      q = a;
      step();
      start_i = 1'b0;
      kill_i  = 1'b0;
      cyc  = 1;
      seen = 1'b0;
      while (cyc <= 40) begin
         if (valid_o) begin
            seen = 1'b1;
            break;
         end
         if (chk_proto) begin
            t = {r, q[31]};
            q = {q[30:0], 1'b0};
            check($sformatf("%s sel@%0d", tag, cyc), {32'd0, multdiv_sel_o}, 33'd1);
            check($sformatf("%s opa@%0d", tag, cyc), multdiv_operand_a_o, {t[31:0], 1'b1});
            check($sformatf("%s opb@%0d", tag, cyc), multdiv_operand_b_o, {~b, 1'b1});
            if (t >= {1'b0, b}) begin
               t    = t - {1'b0, b};
               r    = t[31:0];
               q[0] = 1'b1;
            end else begin
               r = t[31:0];
            end
         end
         step();
         cyc++;
      end
      check({tag, " latency"}, seen ? 33'(cyc) : 33'd0, 33'd33);
      check({tag, " result"}, {1'b0, result_o}, {1'b0, exp});
      if (chk_proto) check({tag, " sel@33"}, {32'd0, multdiv_sel_o}, 33'd0);
      step();
      check({tag, " pulse"}, {32'd0, valid_o}, 33'd0);
      check({tag, " ready@34"}, {32'd0, ready_o}, 33'd1);
      check({tag, " held"}, {1'b0, result_o}, {1'b0, exp});
      $display("op %0d a=%h b=%h -> %h (expect %h)", op, a, b, result_o, exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  vcount;
      step();
      step();
      rst_i = 1'b0;
      check("rst ready",  {32'd0, ready_o}, 33'd1);
      check("rst valid",  {32'd0, valid_o}, 33'd0);
      check("rst result", {1'b0, result_o}, 33'd0);
      check("rst sel",    {32'd0, multdiv_sel_o}, 33'd0);
      check("rst opa",    multdiv_operand_a_o, 33'd0);
      check("rst opb",    multdiv_operand_b_o, 33'd0);

      run_op("mul",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);
      run_op("mulh",     3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
      run_op("mulhu",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_op("mulhsu",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("div",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0);
      run_op("rem",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("divu",     3'd5, 32'd100,        32'd7,         32'd14,        1'b1, 1'b0);
      run_op("remu",     3'd7, 32'd100,        32'd7,         32'd2,         1'b0, 1'b0);
      run_op("div0",     3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("divu0",    3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("rem0",     3'd6, 32'd5,          32'd0,         32'd5,         1'b0, 1'b0);
      run_op("div_ovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
      run_op("rem_ovf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0);
      run_op("kill+start", 3'd5, 32'd100,      32'd7,         32'd14,        1'b0, 1'b1);

      // kill in ITER cycle 10: no result, previous result (14) kept
      start_i = 1'b1; md_op_i = 3'd0; op_a_i = 32'd3; op_b_i = 32'd5;
      for (int i = 0; i < 10; i++) begin
         step();
         start_i = 1'b0;
      end
      kill_i = 1'b1;
      check("kill valid", {32'd0, valid_o}, 33'd0);
      step();
      kill_i = 1'b0;
      check("kill ready",  {32'd0, ready_o}, 33'd1);
      check("kill result", {1'b0, result_o}, 33'd14);
      vcount = 0;
      for (int i = 0; i < 30; i++) begin
         if (valid_o) vcount++;
         step();
      end
      check("kill novalid", 33'(vcount), 33'd0);
      $display("kill: result_o=%h", result_o);

      // reset in ITER cycle 20
      start_i = 1'b1; md_op_i = 3'd1; op_a_i = 32'd9; op_b_i = 32'd9;
      for (int i = 0; i < 20; i++) begin
         step();
         start_i = 1'b0;
      end
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      check("midrst ready",  {32'd0, ready_o}, 33'd1);
      check("midrst valid",  {32'd0, valid_o}, 33'd0);
      check("midrst result", {1'b0, result_o}, 33'd0);
      check("midrst sel",    {32'd0, multdiv_sel_o}, 33'd0);
      check("midrst opa",    multdiv_operand_a_o, 33'd0);
      check("midrst opb",    multdiv_operand_b_o, 33'd0);
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         if (valid_o) vcount++;
         step();
      end
      check("midrst novalid", 33'(vcount), 33'd0);
      $display("reset: result_o=%h", result_o);

      // start while busy is ignored
      start_i = 1'b1; md_op_i = 3'd0; op_a_i = 32'd7; op_b_i = 32'hFFFF_FFFD;
      step();
      start_i = 1'b0;
      for (int i = 1; i < 5; i++) step();
      start_i = 1'b1; md_op_i = 3'd5; op_a_i = 32'd100; op_b_i = 32'd7;
      check("busy ready", {32'd0, ready_o}, 33'd0);
      step();
      start_i = 1'b0;
      for (int i = 6; i < 33; i++) step();
      check("busy valid",  {32'd0, valid_o}, 33'd1);
      check("busy result", {1'b0, result_o}, 33'h0_FFFF_FFEB);
      step();
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         if (valid_o) vcount++;
         step();
      end
      check("busy noqueue", 33'(vcount), 33'd0);
      $display("busy: result_o=%h", result_o);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
